// File: rtl/gfx_bus_pkg.sv
// Shared types and helpers for the graphics bus-master arbiter.
// Imported by the arbiter top and its priority picker.
package gfx_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_OWN  = 2'd2,
      ST_REL  = 2'd3
   } state_e;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

   // Index width for n items; never narrower than one bit.
   function automatic int clog2w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gfx_rr_pick.sv
// Combinational priority picker: first set request at or above a start
// pointer, wrapping; fixed mode scans from index 0.
module gfx_rr_pick
   import gfx_bus_pkg::*;
#(
   parameter int NCH = 4,
   parameter int OW  = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [OW-1:0]  start,
   input  logic           mode,
   output logic [OW-1:0]  idx,
   output logic           valid
);

   logic [OW-1:0]    st;
   logic [NCH-1:0]   rot;

   always_comb begin
      st    = mode ? start : '0;
      rot   = NCH'({req, req} >> st);
      idx   = '0;
      valid = 1'b0;
      // Scan downward so the lowest rotated offset is assigned last.
      for (int i = NCH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            idx   = OW'((int'(st) + i) % NCH);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gfx_bus_arbiter.sv
// Graphics bus-master arbiter: one registered request to the system
// arbiter, one-hot grant to the chosen master, hold limit and bus lock.
module gfx_bus_arbiter
   import gfx_bus_pkg::*;
#(
   parameter  int NCH       = 4,
   parameter  int PRIO_MODE = 0,
   parameter  int HOLD_MAX  = 16,
   localparam int OW        = clog2w(NCH)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [NCH-1:0] req,
   input  logic [NCH-1:0] lock_req,
   input  logic           ack,
   output logic           breq,
   output logic [NCH-1:0] gnt,
   output logic [OW-1:0]  owner,
   output logic           lock,
   output logic           busy
);

   localparam int CW = clog2w(HOLD_MAX + 1);
   localparam logic [CW-1:0] HOLD_SAT = CW'(HOLD_MAX);
   localparam logic [CW-1:0] HOLD_LAST =
      CW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);
   localparam logic [NCH-1:0] ONE  = NCH'(1);
   localparam logic [OW-1:0]  LAST = OW'(NCH - 1);

   state_e          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   rr_q, rr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            resume_q, resume_d;
   logic            breq_q, breq_d;
   logic [NCH-1:0]  gnt_q, gnt_d;
   logic            lock_q, lock_d;
   logic            busy_q, busy_d;

   logic [OW-1:0]   pick_idx;
   logic            pick_vld;
   logic            others;
   logic            time_rel;
   logic            rr_mode;

   assign rr_mode = (PRIO_MODE == PRIO_RR);

   gfx_rr_pick #(
      .NCH (NCH),
      .OW  (OW)
   ) u_pick (
      .req   (req),
      .start (rr_q),
      .mode  (rr_mode),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   always_comb begin
      others   = |(req & ~(ONE << owner_q));
      time_rel = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST)
                 && !lock_req[owner_q] && others;

      state_d  = state_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      resume_d = resume_q;

      unique case (state_q)
         ST_IDLE: begin
            resume_d = 1'b0;
            if (pick_vld) begin
               owner_d = pick_idx;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!req[owner_q]) begin
               state_d  = ST_IDLE;
               resume_d = 1'b0;
            end else if (ack) begin
               state_d  = ST_OWN;
               resume_d = 1'b0;
               // A preempted owner resumes its hold budget.
               if (!resume_q) cnt_d = '0;
            end
         end
         ST_OWN: begin
            cnt_d = (cnt_q == HOLD_SAT) ? cnt_q : cnt_q + 1'b1;
            if (!req[owner_q]) begin
               state_d = ST_REL;
            end else if (!ack) begin
               state_d  = ST_REQ;
               resume_d = 1'b1;
            end else if (time_rel) begin
               state_d = ST_REL;
            end
         end
         ST_REL: begin
            state_d = ST_IDLE;
            if (rr_mode) begin
               rr_d = (owner_q == LAST) ? '0 : owner_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      breq_d = (state_d == ST_REQ) || (state_d == ST_OWN);
      gnt_d  = (state_d == ST_OWN) ? (ONE << owner_d) : '0;
      lock_d = breq_d && lock_req[owner_d];
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         owner_q  <= '0;
         rr_q     <= '0;
         cnt_q    <= '0;
         resume_q <= 1'b0;
         breq_q   <= 1'b0;
         gnt_q    <= '0;
         lock_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         cnt_q    <= cnt_d;
         resume_q <= resume_d;
         breq_q   <= breq_d;
         gnt_q    <= gnt_d;
         lock_q   <= lock_d;
         busy_q   <= busy_d;
      end
   end

   assign breq  = breq_q;
   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign lock  = lock_q;
   assign busy  = busy_q;

endmodule

// File: tb/tb_gfx_bus_arbiter.sv
// Directed bench: fixed-priority arbiter (HOLD_MAX=16) and
// round-robin arbiter (HOLD_MAX=4) side by side.
module tb_gfx_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] req_f, lk_f, gnt_f;
   logic       ack_f, breq_f, lock_f, busy_f;
   logic [1:0] own_f;
   logic [3:0] req_r, lk_r, gnt_r;
   logic       ack_r, breq_r, lock_r, busy_r;
   logic [1:0] own_r;

   int total = 0;
   int bad   = 0;

   gfx_bus_arbiter #(
      .NCH(4), .PRIO_MODE(0), .HOLD_MAX(16)
   ) u_fix (
      .clk(clk), .reset(reset), .req(req_f), .lock_req(lk_f),
      .ack(ack_f), .breq(breq_f), .gnt(gnt_f), .owner(own_f),
      .lock(lock_f), .busy(busy_f)
   );

   gfx_bus_arbiter #(
      .NCH(4), .PRIO_MODE(1), .HOLD_MAX(4)
   ) u_rr (
      .clk(clk), .reset(reset), .req(req_r), .lock_req(lk_r),
      .ack(ack_r), .breq(breq_r), .gnt(gnt_r), .owner(own_r),
      .lock(lock_r), .busy(busy_r)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs;
      req_f = '0; lk_f = '0; ack_f = 1'b0;
      req_r = '0; lk_r = '0; ack_r = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      clr_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      clr_inputs();
      #2;
      total++;
      if ({breq_f, gnt_f, lock_f, busy_f, own_f} !== 9'd0) begin
         bad++;
         $display("FAIL reset_f got=%b exp=0",
                  {breq_f, gnt_f, lock_f, busy_f, own_f});
      end
      total++;
      if ({breq_r, gnt_r, lock_r, busy_r, own_r} !== 9'd0) begin
         bad++;
         $display("FAIL reset_r got=%b exp=0",
                  {breq_r, gnt_r, lock_r, busy_r, own_r});
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single;
      do_reset();
      req_f = 4'b0100;
      tick();
      total++;
      if ({breq_f, gnt_f, own_f} !== {1'b1, 4'b0000, 2'd2}) begin
         bad++;
         $display("FAIL single_req got=%b exp=1000010",
                  {breq_f, gnt_f, own_f});
      end
      ack_f = 1'b1;
      tick();
      total++;
      if ({breq_f, gnt_f} !== 5'b10100) begin
         bad++;
         $display("FAIL single_gnt got=%b exp=10100", {breq_f, gnt_f});
      end
      req_f = 4'b0000;
      tick();
      total++;
      if ({breq_f, gnt_f, busy_f} !== 6'b000001) begin
         bad++;
         $display("FAIL single_rel got=%b exp=000001",
                  {breq_f, gnt_f, busy_f});
      end
      ack_f = 1'b0;
      tick();
      total++;
      if ({breq_f, gnt_f, busy_f} !== 6'b0) begin
         bad++;
         $display("FAIL single_idle got=%b exp=0",
                  {breq_f, gnt_f, busy_f});
      end
   endtask

   task automatic test_fixed;
      do_reset();
      ack_f = 1'b1;
      req_f = 4'b1010;
      tick();
      total++;
      if ({breq_f, own_f} !== 3'b101) begin
         bad++;
         $display("FAIL fixed_own1 got=%b exp=101", {breq_f, own_f});
      end
      tick();
      tick();
      total++;
      if (gnt_f !== 4'b0010) begin
         bad++;
         $display("FAIL fixed_gnt1 got=%b exp=0010", gnt_f);
      end
      req_f = 4'b1000;
      tick();
      total++;
      if ({breq_f, gnt_f} !== 5'b0) begin
         bad++;
         $display("FAIL fixed_rel got=%b exp=0", {breq_f, gnt_f});
      end
      tick();
      tick();
      total++;
      if ({breq_f, own_f} !== 3'b111) begin
         bad++;
         $display("FAIL fixed_own3 got=%b exp=111", {breq_f, own_f});
      end
      tick();
      total++;
      if (gnt_f !== 4'b1000) begin
         bad++;
         $display("FAIL fixed_gnt3 got=%b exp=1000", gnt_f);
      end
      req_f = 4'b0000;
      tick();
      tick();
      ack_f = 1'b0;
      req_f = 4'b0001;
      tick();
      req_f = 4'b0000;
      ack_f = 1'b1;
      tick();
      total++;
      if ({breq_f, gnt_f, busy_f} !== 6'b0) begin
         bad++;
         $display("FAIL withdraw got=%b exp=0", {breq_f, gnt_f, busy_f});
      end
   endtask

   task automatic test_rr;
      int ord[5] = '{0, 1, 2, 3, 0};
      logic [3:0] e;
      do_reset();
      ack_r = 1'b1;
      req_r = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         e = 4'b0001 << ord[n];
         tick();
         total++;
         if (own_r !== 2'(ord[n])) begin
            bad++;
            $display("FAIL rr_owner%0d got=%0d exp=%0d", n, own_r, ord[n]);
         end
         tick();
         tick();
         total++;
         if (gnt_r !== e) begin
            bad++;
            $display("FAIL rr_gnt%0d got=%b exp=%b", n, gnt_r, e);
         end
         req_r = 4'b1111 & ~e;
         tick();
         total++;
         if ({breq_r, gnt_r} !== 5'b0) begin
            bad++;
            $display("FAIL rr_rel%0d got=%b exp=0", n, {breq_r, gnt_r});
         end
         req_r = 4'b1111;
         tick();
      end
   endtask

   task automatic test_hold;
      do_reset();
      ack_r = 1'b1;
      req_r = 4'b0011;
      tick();
      for (int n = 0; n < 4; n++) begin
         tick();
         total++;
         if (gnt_r !== 4'b0001) begin
            bad++;
            $display("FAIL hold_gnt%0d got=%b exp=0001", n, gnt_r);
         end
      end
      tick();
      total++;
      if ({breq_r, gnt_r} !== 5'b0) begin
         bad++;
         $display("FAIL hold_rel got=%b exp=0", {breq_r, gnt_r});
      end
      tick();
      tick();
      total++;
      if ({breq_r, own_r} !== 3'b101) begin
         bad++;
         $display("FAIL hold_own1 got=%b exp=101", {breq_r, own_r});
      end
      tick();
      total++;
      if (gnt_r !== 4'b0010) begin
         bad++;
         $display("FAIL hold_gnt1 got=%b exp=0010", gnt_r);
      end
   endtask

   task automatic test_lock;
      do_reset();
      ack_r = 1'b1;
      lk_r  = 4'b0001;
      req_r = 4'b0011;
      tick();
      total++;
      if ({breq_r, lock_r} !== 2'b11) begin
         bad++;
         $display("FAIL lock_req got=%b exp=11", {breq_r, lock_r});
      end
      for (int n = 0; n < 22; n++) begin
         tick();
         total++;
         if ({gnt_r, lock_r} !== 5'b00011) begin
            bad++;
            $display("FAIL lock_hold%0d got=%b exp=00011", n,
                     {gnt_r, lock_r});
         end
      end
      req_r = 4'b0010;
      tick();
      total++;
      if ({breq_r, gnt_r, lock_r} !== 6'b0) begin
         bad++;
         $display("FAIL lock_drop got=%b exp=0", {breq_r, gnt_r, lock_r});
      end
   endtask

   task automatic test_preempt;
      do_reset();
      ack_r = 1'b1;
      req_r = 4'b0011;
      tick();
      tick();
      tick();
      total++;
      if (gnt_r !== 4'b0001) begin
         bad++;
         $display("FAIL pre_gnt got=%b exp=0001", gnt_r);
      end
      ack_r = 1'b0;
      for (int n = 0; n < 3; n++) begin
         tick();
         total++;
         if ({breq_r, gnt_r} !== 5'b10000) begin
            bad++;
            $display("FAIL pre_wait%0d got=%b exp=10000", n,
                     {breq_r, gnt_r});
         end
      end
      ack_r = 1'b1;
      tick();
      total++;
      if ({gnt_r, own_r} !== 6'b000100) begin
         bad++;
         $display("FAIL pre_back got=%b exp=000100", {gnt_r, own_r});
      end
      tick();
      total++;
      if (gnt_r !== 4'b0001) begin
         bad++;
         $display("FAIL pre_cnt4 got=%b exp=0001", gnt_r);
      end
      tick();
      total++;
      if ({breq_r, gnt_r} !== 5'b0) begin
         bad++;
         $display("FAIL pre_rel got=%b exp=0", {breq_r, gnt_r});
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      ack_f = 1'b1;
      lk_f  = 4'b0001;
      req_f = 4'b0001;
      tick();
      tick();
      total++;
      if ({gnt_f, lock_f} !== 5'b00011) begin
         bad++;
         $display("FAIL mid_own got=%b exp=00011", {gnt_f, lock_f});
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if ({breq_f, gnt_f, lock_f, busy_f} !== 7'b0) begin
         bad++;
         $display("FAIL mid_async got=%b exp=0",
                  {breq_f, gnt_f, lock_f, busy_f});
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      total++;
      if ({breq_f, gnt_f, own_f} !== 7'b1000000) begin
         bad++;
         $display("FAIL mid_req got=%b exp=1000000",
                  {breq_f, gnt_f, own_f});
      end
      tick();
      total++;
      if (gnt_f !== 4'b0001) begin
         bad++;
         $display("FAIL mid_gnt got=%b exp=0001", gnt_f);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fixed();
      test_rr();
      test_hold();
      test_lock();
      test_preempt();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gfx_bus_arbiter.md
# gfx_bus_arbiter

Parametrised bus-master arbiter for the graphics unit: collects bus requests from NCH internal masters (GPU, blitter read/write, DMA), raises a single registered bus request to the system arbiter, and on `ack` passes a one-hot grant to the chosen master. It supports fixed or round-robin priority, a bounded hold time with preemption, and a bus lock. It sits between the graphics masters and the system memory controller and replaces the hard-wired per-master `*_breq` outputs.

## Interface
Parameters:
- `NCH`, 4, number of requesting masters (2..8).
- `PRIO_MODE`, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- `HOLD_MAX`, 16, maximum owned cycles before forced release when others wait; 0 = unlimited.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous active-high reset.
- `req`  in  NCH  per-master bus request, level, held until done.
- `lock_req`  in  NCH  per-master request to hold the bus unpreempted.
- `ack`  in  1  bus granted by the system arbiter, level.
- `breq`  out  1  registered bus request to the system arbiter.
- `gnt`  out  NCH  one-hot grant (per-master bus acknowledge).
- `owner`  out  clog2(NCH)  index of the current or pending owner.
- `lock`  out  1  system bus lock.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, REQ, OWN, REL.
- IDLE: if any `req`, `owner` <= pick(`req`) -> REQ.
- REQ: `breq`=1. If `req[owner]`=0 -> IDLE (withdrawn, no pointer update). Else if `ack` -> OWN, `cnt`<=0.
- OWN: `breq`=1, `gnt`=onehot(`owner`), `cnt` increments, saturating at HOLD_MAX. Exits, in priority order:
  - `req[owner]`=0 -> REL.
  - `ack`=0 (system preemption) -> REQ, same owner, `cnt` kept.
  - HOLD_MAX!=0, `cnt`==HOLD_MAX-1, `lock_req[owner]`=0, and another `req` bit set -> REL.
  - Otherwise stay in OWN.
- REL: `breq`=0, `gnt`=0. One cycle, then -> IDLE. In round-robin mode the pointer `rr` <= owner+1, wrapping to 0 at NCH.
- pick:
  - Fixed mode: lowest set index.
  - RR mode: first set index at or above `rr`, wrapping.
  - `req` is sampled only in IDLE; changes in other states do not alter `owner`.
- `lock` = (`state`==REQ or OWN) and `lock_req[owner]`. A locked owner is never time-released, but it is still released on `req` drop or on `ack` loss.
- Width rules: `cnt` has width clog2(HOLD_MAX+1) and does not wrap. `rr` has width clog2(NCH).

## Timing
- All outputs are registered decodes of state. Reset values: `breq`=0, `gnt`=0, `lock`=0, `busy`=0, `owner`=0, `rr`=0, `cnt`=0, state IDLE.
- `req` high before edge k -> `breq` high after edge k.
- `ack` high before edge m (m>k) -> `gnt` high after edge m. Minimum `req`-to-`gnt` latency is 2 cycles.
- `req[owner]` low before edge n -> `gnt` and `breq` low after edge n (REL). The earliest next `breq` is after edge n+2.
- `ack` low before edge p -> `gnt` low after edge p, while `breq` stays high.
- Hold limit: with others waiting, `gnt` is high for exactly HOLD_MAX cycles.
- Reset mid-operation: all outputs drop asynchronously to their reset values, with no REL cycle.
- Simultaneous events: `ack` arriving in the same cycle as `req[owner]` drop in REQ -> IDLE (the withdrawal wins). `gnt` is never multi-hot.

## Structure
- Shared package `gfx_bus_pkg`:
  - state enum (IDLE/REQ/OWN/REL),
  - `PRIO_FIXED`=0 and `PRIO_RR`=1,
  - a function returning clog2 widths.
- Sub-module `gfx_rr_pick`: combinational NCH-wide priority picker with a start pointer and a mode input, outputting an index and a valid flag. Fixed mode ties the start pointer to 0.
- Top level: FSM, hold counter, `rr` pointer, output registers.

## Test plan
- Single master: `req`=4'b0100, `ack` returned 1 cycle after `breq` -> `gnt`=4'b0100 exactly 2 cycles after `req`, `owner`=2. Drop `req` -> REL, then `breq`=0 and `gnt`=0 for 1 cycle.
- Fixed priority: `req`=4'b1010 from IDLE -> `owner`=1. After its release with `req[3]` still high -> `owner`=3.
- Round-robin (PRIO_MODE=1), `req`=4'b1111 held, each owner dropping after 2 grant cycles -> grant order 0,1,2,3,0.
- Hold limit (HOLD_MAX=4): `req`=4'b0011, master 0 never drops -> `gnt[0]` high for 4 cycles, REL, then `gnt[1]`. Repeat with `lock_req[0]`=1 -> `gnt[0]` held 20+ cycles and `lock`=1.
- Preemption: `ack` drops for 3 cycles during OWN -> `gnt`=0 and `breq`=1 for 3 cycles, then `gnt` returns to the same owner with `cnt` continuing.
- Reset asserted in OWN mid-grant -> `gnt`, `breq` and `lock` are 0 before the next edge. After reset release with `req` still high -> normal 2-cycle grant to `owner`=0.
